// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - async FIFO read-side drain onto a framed valid/ready stream
// Pops are issued only when the 3-entry skid buffer has room for every word in flight.
module fifo_rd_stream #(
  parameter int DSIZE     = 12,
  parameter int FRAME_LEN = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             fifo_rempty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_rinc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  output logic [15:0]      frame_cnt
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  logic [DSIZE-1:0] mem [3];
  logic [1:0]       head;
  logic [1:0]       tail;
  logic [1:0]       cnt;
  logic             inflight;
  logic [IW-1:0]    idx;
  logic             xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Space is reserved for the word still on fifo_rdata, so capture never overflows.
  always_comb begin
    fifo_rinc = ~rrst & en & ~fifo_rempty & (({1'b0, cnt} + {2'b00, inflight}) < 3'd3);
  end

  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[head];
  assign out_last  = out_valid & (idx == IDX_LAST);
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      head      <= 2'd0;
      tail      <= 2'd0;
      cnt       <= 2'd0;
      inflight  <= 1'b0;
      idx       <= '0;
      frame_cnt <= 16'd0;
    end else begin
      inflight <= fifo_rinc;
      if (inflight) begin
        mem[tail] <= fifo_rdata;
        tail      <= ptr_inc(tail);
      end
      if (xfer) head <= ptr_inc(head);
      cnt <= cnt + {1'b0, inflight} - {1'b0, xfer};
      if (xfer) begin
        idx <= out_last ? '0 : idx + 1'b1;
        if (out_last) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
